// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and types for the fetch stage.
//   XLEN          - address/data width in bits
//   RESET_PC_ADDR - PC value while reset is asserted
//   PC_STEP       - sequential instruction stride in bytes
//   addr_t        - XLEN-bit address type
package cpu_pkg;
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_ADDR = 32'h0000_0000;
    localparam int unsigned PC_STEP = 4;
    typedef logic [XLEN-1:0] addr_t;
endpackage

// File: rtl/pc.sv
// pc: program counter register for the fetch stage, advancing by 4 or loading a redirect target.
//   clk_i         - system clock, rising edge
//   rst_i         - synchronous active-high reset, overrides pc_load_i
//   pc_load_i     - redirect strobe, level sampled each edge
//   pc_load_val_i - redirect target, loaded unmodified
//   pc_o          - current PC (registered)
//   pc_plus4_o    - pc_o + 4 (combinational, modulo 2^XLEN)
module pc #(
    parameter int unsigned XLEN = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC_ADDR = cpu_pkg::RESET_PC_ADDR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_load_i,
    input  logic [XLEN-1:0] pc_load_val_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);
    import cpu_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d, pc_inc;

    // Single incrementer shared by the next-PC mux and the link value; carry is dropped.
    assign pc_inc = pc_q + XLEN'(PC_STEP);
    assign pc_d   = pc_load_i ? pc_load_val_i : pc_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) pc_q <= RESET_PC_ADDR;
        else       pc_q <= pc_d;
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_inc;
endmodule

// File: tb/tb_pc.sv
// tb_pc: table-driven self-checking bench for the program counter.
module tb_pc;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        pc_load_i = 1'b0;
    logic [31:0] pc_load_val_i = 32'h0;
    logic [31:0] pc_o, pc_plus4_o;

    int total = 0;
    int passed = 0;

    pc dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .pc_load_i(pc_load_i),
        .pc_load_val_i(pc_load_val_i),
        .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        load;
        logic [31:0] val;
        logic [31:0] exp_pc;
        logic [31:0] exp_p4;
    } vec_t;

    vec_t v[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    initial begin
        v[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
        v[1]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
        v[2]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        v[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C};
        v[4]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        v[5]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        v[6]  = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0004};
        v[7]  = '{1'b0, 1'b0, 32'h0000_0200, 32'h0000_0004, 32'h0000_0008};
        v[8]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        v[9]  = '{1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0004};
        v[10] = '{1'b0, 1'b1, 32'h0000_0102, 32'h0000_0102, 32'h0000_0106};
        v[11] = '{1'b0, 1'b1, 32'h0000_0102, 32'h0000_0102, 32'h0000_0106};
        v[12] = '{1'b0, 1'b1, 32'hABCD_EF01, 32'hABCD_EF01, 32'hABCD_EF05};
        v[13] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 32'hABCD_EF05, 32'hABCD_EF09};
        v[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst_i = v[i].rst;
            pc_load_i = v[i].load;
            pc_load_val_i = v[i].val;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d pc", i), pc_o, v[i].exp_pc);
            check($sformatf("vec%0d pc_plus4", i), pc_plus4_o, v[i].exp_p4);
        end

        // Release reset, advance to 0x4, then toggle rst_i between edges: PC must hold.
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset pc", pc_o, 32'h0000_0004);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("async_rst pc", pc_o, 32'h0000_0004);
        rst_i = 1'b0;
        #1;
        check("async_rst_release pc", pc_o, 32'h0000_0004);

        // pc_plus4_o must ignore the load inputs between edges.
        pc_load_i = 1'b1;
        pc_load_val_i = 32'h0000_0800;
        #1;
        check("p4_indep_load", pc_plus4_o, 32'h0000_0008);
        check("pc_indep_load", pc_o, 32'h0000_0004);
        @(posedge clk);
        #1;
        check("late_load pc", pc_o, 32'h0000_0800);
        @(negedge clk);
        pc_load_i = 1'b0;
        @(posedge clk);
        #1;
        check("after_late_load pc", pc_o, 32'h0000_0804);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc.md
Name: pc

Overview:
- Program counter register for the RISC-V CPU fetch stage.
- Holds the address of the current instruction.
- Each cycle it advances by 4 or loads a redirect target from branch/jump resolution.
- Exposes the current PC and PC+4; PC+4 feeds the next-PC path and the link-register write-back (JAL/JALR).

Parameters:
- XLEN, 32 (from cpu_pkg): address/data width in bits.
- RESET_PC_ADDR, 32'h0000_0000 (from cpu_pkg): value loaded into PC while reset is asserted.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- pc_load_i  input  1  redirect strobe; when high, PC takes pc_load_val_i on the next rising edge.
- pc_load_val_i  input  XLEN  redirect target address (branch/jump).
- pc_o  output  XLEN  current PC, registered.
- pc_plus4_o  output  XLEN  pc_o + 4, combinational.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Single XLEN-bit register pc_q drives pc_o directly; no other state.
- Update at each rising edge of clk_i, in priority order:
  - rst_i = 1: pc_q <= RESET_PC_ADDR. Reset overrides pc_load_i.
  - else pc_load_i = 1: pc_q <= pc_load_val_i.
  - else: pc_q <= pc_q + 4.
- Reset value: pc_o = RESET_PC_ADDR; pc_plus4_o = RESET_PC_ADDR + 4.
- Reset is synchronous only, so pc_o does not change between clock edges when rst_i toggles.
- While rst_i is held, pc_o stays at RESET_PC_ADDR on every edge.
- First edge with rst_i low: pc_o = RESET_PC_ADDR + 4, or pc_load_val_i if pc_load_i is high.
- Latency:
  - load takes effect 1 cycle after pc_load_i is sampled high;
  - pc_load_i is a level sampled each edge, with no handshake or acknowledge;
  - holding it high reloads pc_load_val_i on every edge.
- pc_plus4_o:
  - purely combinational from pc_q; updates in the same cycle as pc_o;
  - never depends on pc_load_i or pc_load_val_i.
- Arithmetic:
  - unsigned, modulo 2^XLEN;
  - 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, for both the increment and pc_plus4_o;
  - carry out is discarded.
- Alignment:
  - pc_load_val_i is loaded unmodified, including bits [1:0];
  - no alignment checking or exception generation here, since misalignment is handled by the fetch/exception logic.
- No stall/enable input: PC advances every cycle when not in reset and not loading.
- No X propagation from an undriven pc_load_val_i while pc_load_i = 0; the output depends only on selected sources.

Decomposition:
- cpu_pkg holds:
  - XLEN = 32;
  - RESET_PC_ADDR = 32'h0000_0000;
  - addr_t typedef (logic [XLEN-1:0]);
  - PC_STEP = 4.
- The module imports cpu_pkg; the parameters default to the package constants.
- No sub-module. The incrementer is one adder whose result is shared by the next-PC mux and pc_plus4_o.

Test Plan:
- Reset: hold rst_i = 1 for 2 edges -> pc_o = 0x0000_0000, pc_plus4_o = 0x0000_0004.
- Increment: release reset, 2 edges -> pc_o = 0x04 then 0x08; pc_plus4_o = pc_o + 4 at every check.
- Load: drive pc_load_val_i = 0x100 and pc_load_i = 1 on a negedge -> after next posedge pc_o = 0x100, pc_plus4_o = 0x104. Drop pc_load_i -> next edge pc_o = 0x104.
- Reset vs load: rst_i = 1 with pc_load_i = 1 and pc_load_val_i = 0x200 -> pc_o = 0x0, proving reset priority.
- Mid-run reset: from pc_o = 0x104, assert rst_i for 1 edge -> pc_o = 0x0. Deassert -> next edge pc_o = 0x4.
- Wrap: load 0xFFFF_FFFC -> pc_plus4_o = 0x0000_0000; next edge without load -> pc_o = 0x0000_0000. Load 0x0000_0102 (unaligned) -> pc_o = 0x102 unchanged.
